// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready holding register, framing and overrun reporting.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 majority vote around every sample point.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLKS_PER_BIT = 1087,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_input,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the nominal point, so the start decision is one count later;
    // every later decision then lands on the last count with the nominal point at mid.
    localparam logic [15:0] START_LAST = 16'(CLKS_PER_BIT / 2);
`else
    localparam logic [15:0] START_LAST = 16'(CLKS_PER_BIT / 2 - 1);
`endif

    state_t                   state, next_state;
    logic [SYNC_STAGES-1:0]   sync;
    logic                     rxs, rxs_d;
    logic                     sample;
    logic [15:0]              baud_cnt;
    logic [2:0]               bit_idx;
    logic [7:0]               shift;
    logic                     tick, stop_good, stop_bad, shift_en;
    logic                     byte_done;

    assign rxs = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            rxs_d <= 1'b1;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], rx_input};
            rxs_d <= rxs;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxs_dd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rxs_dd <= 1'b1;
        else        rxs_dd <= rxs_d;
    end

    assign sample = (rxs & rxs_d) | (rxs & rxs_dd) | (rxs_d & rxs_dd);
`else
    assign sample = rxs;
`endif

    // State register with the baud and bit counters that follow it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            state <= next_state;
            if (state != next_state || state == IDLE || baud_cnt == BIT_LAST)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 16'd1;
            if (state != DATA)
                bit_idx <= '0;
            else if (tick)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (rxs_d && !rxs) next_state = START;
            START: if (tick) next_state = sample ? IDLE : DATA;
            DATA:  if (tick && bit_idx == 3'd7) next_state = STOP;
            STOP:  if (tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tick      = (state == START) ? (baud_cnt == START_LAST) : (baud_cnt == BIT_LAST);
        busy      = (state != IDLE);
        shift_en  = (state == DATA) && tick;
        stop_good = (state == STOP) && tick && sample;
        stop_bad  = (state == STOP) && tick && !sample;
    end

    // Data-only shift register, LSB arrives first so bits enter at the top
    always_ff @(posedge clk) begin
        if (shift_en) shift <= {sample, shift[7:1]};
    end

    // Holding register: one cycle after a good stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_done   <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
        end else begin
            byte_done   <= stop_good;
            frame_err   <= stop_bad;
            overrun_err <= byte_done && rx_valid && !rx_ready;
            if (byte_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, handshake, errors, glitches and reset.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_input = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun_err, busy;

    int n_vec = 0;
    int n_err = 0;

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .rx_input(rx_input), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .frame_err(frame_err),
        .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    logic [7:0] got[$];
    int         valid_cycles = 0, ferr_cnt = 0, ovr_cnt = 0, rise_cyc = 0;
    logic       valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (rx_valid) valid_cycles = valid_cycles + 1;
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (overrun_err) ovr_cnt = ovr_cnt + 1;
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input bit spike);
        for (int i = 0; i < CPB; i++) begin
            rx_input = (spike && i == CPB / 2) ? ~v : v;
            tick(1);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input bit spike);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], spike);
        send_bit(stop, 1'b0);
    endtask

    initial begin
        int base_q, base_v, base_f, base_o, start_cyc, lat;
        logic [7:0] spike_exp;
        logic [7:0] abc [6];
        abc = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

        // reset values
        tick(3);
        chk("reset_valid", 32'(rx_valid), 32'd0);
        chk("reset_data", 32'(rx_data), 32'd0);
        chk("reset_ferr", 32'(frame_err), 32'd0);
        chk("reset_ovr", 32'(overrun_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(5);

        // single byte 'A'
        base_q = got.size(); base_v = valid_cycles; base_f = ferr_cnt;
        start_cyc = cyc;
        send_byte(8'h41, 1'b1, 1'b0);
        tick(4);
        lat = rise_cyc - start_cyc;
        chk("a_count", 32'(got.size() - base_q), 32'd1);
        chk("a_data", 32'(got[base_q]), 32'h41);
        chk("a_valid_cycles", 32'(valid_cycles - base_v), 32'd1);
        chk("a_ferr", 32'(ferr_cnt - base_f), 32'd0);
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_latency_window", 32'(lat >= 155 && lat <= 158), 32'd1);

        // back-to-back 'A'..'F'
        base_q = got.size(); base_f = ferr_cnt; base_o = ovr_cnt;
        for (int i = 0; i < 6; i++) send_byte(abc[i], 1'b1, 1'b0);
        tick(4);
        chk("b2b_count", 32'(got.size() - base_q), 32'd6);
        for (int i = 0; i < 6; i++) chk("b2b_data", 32'(got[base_q + i]), 32'(abc[i]));
        chk("b2b_ovr", 32'(ovr_cnt - base_o), 32'd0);
        chk("b2b_ferr", 32'(ferr_cnt - base_f), 32'd0);

        // overrun with consumer stalled
        rx_ready = 1'b0;
        base_q = got.size(); base_o = ovr_cnt;
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        tick(4);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        chk("ovr_data", 32'(rx_data), 32'h55);
        chk("ovr_pulses", 32'(ovr_cnt - base_o), 32'd1);
        rx_ready = 1'b1;
        tick(1);
        chk("ovr_drop_valid", 32'(rx_valid), 32'd0);
        chk("ovr_accepted", 32'(got[got.size() - 1]), 32'h55);
        chk("ovr_accept_count", 32'(got.size() - base_q), 32'd1);

        // framing error, line held low, then a good byte
        base_q = got.size(); base_v = valid_cycles; base_f = ferr_cnt;
        send_byte(8'h3C, 1'b0, 1'b0);
        tick(3 * CPB);
        rx_input = 1'b1;
        tick(2 * CPB);
        chk("fe_pulses", 32'(ferr_cnt - base_f), 32'd1);
        chk("fe_no_valid", 32'(valid_cycles - base_v), 32'd0);
        send_byte(8'h7E, 1'b1, 1'b0);
        tick(4);
        chk("fe_after_count", 32'(got.size() - base_q), 32'd1);
        chk("fe_after_data", 32'(got[base_q]), 32'h7E);
        chk("fe_no_more_ferr", 32'(ferr_cnt - base_f), 32'd1);

        // short low glitch on an idle line
        base_v = valid_cycles; base_f = ferr_cnt;
        rx_input = 1'b0;
        tick(4);
        rx_input = 1'b1;
        tick(2);
        chk("glitch_busy_in_start", 32'(busy), 32'd1);
        tick(3 * CPB);
        chk("glitch_busy_idle", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(valid_cycles - base_v), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - base_f), 32'd0);

        // reset in the middle of D3
        base_q = got.size(); base_f = ferr_cnt; base_o = ovr_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        rx_input = 1'b0;
        tick(CPB / 2);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        rx_input = 1'b1;
        tick(3);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun_err), 32'd0);
        rst_n = 1'b1;
        tick(2 * CPB);
        send_byte(8'h81, 1'b1, 1'b0);
        tick(4);
        chk("rst_after_count", 32'(got.size() - base_q), 32'd1);
        chk("rst_after_data", 32'(got[base_q]), 32'h81);
        chk("rst_no_err", 32'(ferr_cnt - base_f + ovr_cnt - base_o), 32'd0);

        // mid-bit spikes: rejected by the vote, sampled directly otherwise
`ifdef UART_RX_MAJORITY_EN
        spike_exp = 8'hC3;
`else
        spike_exp = 8'h3C;
`endif
        base_q = got.size();
        send_byte(8'hC3, 1'b1, 1'b1);
        tick(4);
        chk("spike_count", 32'(got.size() - base_q), 32'd1);
        chk("spike_data", 32'(rx_data), 32'(spike_exp));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
